// File: rtl/skinny_ctrl_pkg.sv
// skinny_ctrl_pkg: shared constants and FSM encoding for the SKINNY S-box layer scheduler
package skinny_ctrl_pkg;
  localparam int NIB = 16;
  localparam int CNT_W = 5;
  typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;
endpackage

// File: rtl/skinny_sbox_layer_ctrl_share_nibble_shifter.sv
// share_nibble_shifter: 64-bit share register with parallel load and MSB-out/LSB-in nibble shift
module share_nibble_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        shift,
  input  logic [63:0] din,
  input  logic [3:0]  nib_in,
  output logic [63:0] q
);
  logic [63:0] data_q, data_d;
  always_comb data_d = load ? din : shift ? {data_q[59:0], nib_in} : data_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) data_q <= '0;
    else data_q <= data_d;
  assign q = data_q;
endmodule

// File: rtl/skinny_sbox_layer_ctrl.sv
// skinny_sbox_layer_ctrl: nibble-serial 3-share S-box layer scheduler around an external pipelined S-box
module skinny_sbox_layer_ctrl
  import skinny_ctrl_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] state_in1,
  input  logic [63:0] state_in2,
  input  logic [63:0] state_in3,
  output logic        busy,
  output logic        done,
  output logic [63:0] state_out1,
  output logic [63:0] state_out2,
  output logic [63:0] state_out3,
  output logic        sb_en,
  output logic [3:0]  sb_x1,
  output logic [3:0]  sb_x2,
  output logic [3:0]  sb_x3,
  input  logic [3:0]  sb_y1,
  input  logic [3:0]  sb_y2,
  input  logic [3:0]  sb_y3
);
  localparam logic [CNT_W-1:0] LAST_FEED = CNT_W'(NIB - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(NIB - 1 + LAT);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic feed, drain, load, capture;
  logic [63:0] din [3];
  logic [63:0] dout [3];
  logic [3:0] x [3];
  logic [3:0] y [3];
  logic [59:0] unused_lo [3];
  assign din[0] = state_in1;
  assign din[1] = state_in2;
  assign din[2] = state_in3;
  assign y[0] = sb_y1;
  assign y[1] = sb_y2;
  assign y[2] = sb_y3;
  always_comb begin
    feed = state_q == FEED;
    drain = state_q == DRAIN;
    load = state_q == IDLE && start;
    capture = (feed || drain) && cnt_q >= LAT_C;
    cnt_d = (feed || drain) ? cnt_q + 1'b1 : '0;
    state_d = (state_q == IDLE) ? (start ? FEED : IDLE) :
              feed ? (cnt_q == LAST_FEED ? DRAIN : FEED) :
              drain ? (cnt_q == LAST_DRAIN ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  // input registers empty themselves while feeding, so their MSB nibble is already 0 outside FEED
  for (genvar i = 0; i < 3; i++) begin : g_share
    share_nibble_shifter u_in (
      .clk(clk), .rst(rst), .load(load), .shift(feed), .din(din[i]), .nib_in(4'h0),
      .q({x[i], unused_lo[i]})
    );
    share_nibble_shifter u_out (
      .clk(clk), .rst(rst), .load(1'b0), .shift(capture), .din(64'h0), .nib_in(y[i]),
      .q(dout[i])
    );
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign sb_en = feed || drain;
  assign sb_x1 = x[0];
  assign sb_x2 = x[1];
  assign sb_x3 = x[2];
  assign state_out1 = dout[0];
  assign state_out2 = dout[1];
  assign state_out3 = dout[2];
endmodule

// File: tb/tb_skinny_sbox_layer_ctrl.sv
// tb_skinny_sbox_layer_ctrl: scoreboard bench for the S-box layer scheduler at LAT=4, 1 and 15
module tb_skinny_sbox_layer_ctrl;
  localparam logic [63:0] STAB = 64'hF7E4_D583_B2A1_096C;
  localparam logic [63:0] A1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] A2 = 64'hFEDCBA9876543210;
  localparam logic [63:0] A3 = 64'h0F0F0F0F0F0F0F0F;
  typedef struct packed {logic rl; logic [63:0] e1; logic [63:0] e2; logic [63:0] e3;} exp_t;
  exp_t sbq[$];
  logic clk = 0, rst = 0, start = 0, real_mode = 0;
  logic [63:0] in1 = 0, in2 = 0, in3 = 0;
  logic busy_a [3];
  logic done_a [3];
  logic en_a [3];
  logic [63:0] so_a [3][3];
  logic [3:0] x_a [3][3];
  int vec = 0, bad = 0;
  always #5 clk = ~clk;

  function automatic logic [3:0] sb(input logic [3:0] v);
    return STAB[4*v +: 4];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : 15;
    logic [3:0] pipe [L][3];
    logic [3:0] r1, r2;
    skinny_sbox_layer_ctrl #(.LAT(L)) dut (
      .clk(clk), .rst(rst), .start(start),
      .state_in1(in1), .state_in2(in2), .state_in3(in3),
      .busy(busy_a[g]), .done(done_a[g]),
      .state_out1(so_a[g][0]), .state_out2(so_a[g][1]), .state_out3(so_a[g][2]),
      .sb_en(en_a[g]), .sb_x1(x_a[g][0]), .sb_x2(x_a[g][1]), .sb_x3(x_a[g][2]),
      .sb_y1(pipe[L-1][0]), .sb_y2(pipe[L-1][1]), .sb_y3(pipe[L-1][2])
    );
    always @(negedge clk) begin
      r1 <= 4'($urandom);
      r2 <= 4'($urandom);
    end
    always @(posedge clk or posedge rst)
      if (rst) begin
        for (int j = 0; j < L; j++) for (int s = 0; s < 3; s++) pipe[j][s] <= '0;
      end else if (en_a[g]) begin
        pipe[0][0] <= real_mode ? r1 : x_a[g][0];
        pipe[0][1] <= real_mode ? r2 : x_a[g][1];
        pipe[0][2] <= real_mode ? (sb(x_a[g][0] ^ x_a[g][1] ^ x_a[g][2]) ^ r1 ^ r2) : x_a[g][2];
        for (int j = 1; j < L; j++) for (int s = 0; s < 3; s++) pipe[j][s] <= pipe[j-1][s];
      end
  end

  always @(negedge clk)
    if (!rst && done_a[0]) begin
      exp_t e;
      vec++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected: got done=1 with nothing pending, want done=0");
      end else begin
        e = sbq.pop_front();
        if (e.rl) begin
          if ((so_a[0][0] ^ so_a[0][1] ^ so_a[0][2]) !== 64'hCCCCCCCCCCCCCCCC) begin
            bad++;
            $display("FAIL sbox_xor: got %h want cccccccccccccccc", so_a[0][0] ^ so_a[0][1] ^ so_a[0][2]);
          end
        end else if ({so_a[0][0], so_a[0][1], so_a[0][2]} !== {e.e1, e.e2, e.e3}) begin
          bad++;
          $display("FAIL identity_out: got %h %h %h want %h %h %h", so_a[0][0], so_a[0][1], so_a[0][2], e.e1, e.e2, e.e3);
        end
        vec++;
        if (en_a[0] !== 1'b0 || busy_a[0] !== 1'b1) begin
          bad++;
          $display("FAIL done_flags: got sb_en=%b busy=%b want 0 1", en_a[0], busy_a[0]);
        end
      end
    end

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic rl);
    int dc [3];
    int nb, ne;
    logic [63:0] ins [3];
    ins = '{a, b, c};
    dc = '{-1, -1, -1};
    nb = 0;
    ne = 0;
    @(negedge clk);
    real_mode = rl;
    in1 = a; in2 = b; in3 = c; start = 1;
    sbq.push_back({rl, a, b, c});
    @(posedge clk);
    #1 start = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (busy_a[0]) nb++;
      if (en_a[0]) ne++;
      if (cyc <= 21)
        for (int s = 0; s < 3; s++) begin
          logic [3:0] ex;
          ex = (cyc <= 16) ? ins[s][63-4*(cyc-1) -: 4] : 4'h0;
          vec++;
          if (x_a[0][s] !== ex) begin
            bad++;
            $display("FAIL sb_x%0d cycle %0d: got %h want %h", s + 1, cyc, x_a[0][s], ex);
          end
        end
      for (int k = 1; k < 3; k++)
        if (done_a[k] && dc[k] < 0) begin
          dc[k] = cyc;
          if (!rl) begin
            vec++;
            if ({so_a[k][0], so_a[k][1], so_a[k][2]} !== {a, b, c}) begin
              bad++;
              $display("FAIL lat_dut%0d_data: got %h %h %h want %h %h %h", k, so_a[k][0], so_a[k][1], so_a[k][2], a, b, c);
            end
          end
        end
      if (done_a[0] && dc[0] < 0) dc[0] = cyc;
    end
    vec += 5;
    if (dc[0] != 21) begin bad++; $display("FAIL done_cycle_lat4: got %0d want 21", dc[0]); end
    if (dc[1] != 18) begin bad++; $display("FAIL done_cycle_lat1: got %0d want 18", dc[1]); end
    if (dc[2] != 32) begin bad++; $display("FAIL done_cycle_lat15: got %0d want 32", dc[2]); end
    if (nb != 21) begin bad++; $display("FAIL busy_cycles: got %0d want 21", nb); end
    if (ne != 20) begin bad++; $display("FAIL sb_en_cycles: got %0d want 20", ne); end
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done_a[0]) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 rst = 1;
    #1;
    vec++;
    if ({busy_a[0], done_a[0], en_a[0], x_a[0][0], x_a[0][1], x_a[0][2]} !== 15'h0 ||
        {so_a[0][0], so_a[0][1], so_a[0][2]} !== 192'h0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b en=%b x=%h%h%h out=%h", busy_a[0], done_a[0], en_a[0],
               x_a[0][0], x_a[0][1], x_a[0][2], so_a[0][0] | so_a[0][1] | so_a[0][2]);
    end
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    vec++;
    if (busy_a[0] !== 1'b0) begin bad++; $display("FAIL idle_after_reset: got busy=%b want 0", busy_a[0]); end
  endtask

  task automatic test_identity;
    run_op(A1, A2, A3, 0);
    run_op(64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h8000000000000001, 0);
  endtask

  task automatic test_real_sbox;
    for (int i = 0; i < 3; i++) begin
      logic [63:0] r1, r2;
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      run_op(r1, r2, r1 ^ r2, 1);
    end
    real_mode = 0;
  endtask

  task automatic test_ignored_start;
    int dn, dcyc;
    dn = 0;
    dcyc = -1;
    @(negedge clk);
    in1 = A3; in2 = A1; in3 = A2; start = 1;
    sbq.push_back({1'b0, A3, A1, A2});
    @(posedge clk);
    #1 start = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 5) begin start = 1; in1 = '1; in2 = '1; in3 = '1; end
      if (cyc == 6) start = 0;
      if (dcyc >= 0 && cyc == dcyc + 1) start = 0;
      if (done_a[0]) begin
        dn++;
        if (dcyc < 0) begin dcyc = cyc; start = 1; end
      end
    end
    vec += 3;
    if (dn != 1) begin bad++; $display("FAIL ignored_start_done_count: got %0d want 1", dn); end
    if (dcyc != 21) begin bad++; $display("FAIL ignored_start_done_cycle: got %0d want 21", dcyc); end
    if ({so_a[0][0], so_a[0][1], so_a[0][2]} !== {A3, A1, A2}) begin
      bad++;
      $display("FAIL ignored_start_hold: got %h %h %h want %h %h %h", so_a[0][0], so_a[0][1], so_a[0][2], A3, A1, A2);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int c1, c2;
    @(negedge clk);
    in1 = A2; in2 = A3; in3 = A1; start = 1;
    sbq.push_back({1'b0, A2, A3, A1});
    @(posedge clk);
    #1 start = 0;
    wait_done(c1);
    @(negedge clk);
    in1 = A1; in2 = ~A1; in3 = A2 ^ A3; start = 1;
    sbq.push_back({1'b0, A1, ~A1, A2 ^ A3});
    @(posedge clk);
    #1 start = 0;
    wait_done(c2);
    vec += 2;
    if (c1 != 21) begin bad++; $display("FAIL b2b_first_done: got %0d want 21", c1); end
    if (c2 != 21) begin bad++; $display("FAIL b2b_second_done: got %0d want 21", c2); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_async_reset;
    int dn;
    dn = 0;
    @(negedge clk);
    in1 = A1; in2 = A2; in3 = A3; start = 1;
    sbq.push_back({1'b0, A1, A2, A3});
    @(posedge clk);
    #1 start = 0;
    repeat (8) @(negedge clk);
    vec++;
    if (x_a[0][0] !== 4'h7) begin bad++; $display("FAIL pre_reset_cnt7: got sb_x1=%h want 7", x_a[0][0]); end
    #1 rst = 1;
    #1;
    vec++;
    if ({busy_a[0], done_a[0], en_a[0], x_a[0][0], x_a[0][1], x_a[0][2]} !== 15'h0 ||
        {so_a[0][0], so_a[0][1], so_a[0][2]} !== 192'h0) begin
      bad++;
      $display("FAIL async_reset_clear: got busy=%b en=%b x=%h%h%h out=%h want all 0", busy_a[0], en_a[0],
               x_a[0][0], x_a[0][1], x_a[0][2], so_a[0][0] | so_a[0][1] | so_a[0][2]);
    end
    sbq.delete();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a[0]) dn++;
    end
    vec++;
    if (dn != 0) begin bad++; $display("FAIL abort_done_pulse: got %0d want 0", dn); end
    run_op(A1, A2, A3, 0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_real_sbox();
    test_ignored_start();
    test_back_to_back();
    test_async_reset();
    repeat (5) @(negedge clk);
    vec++;
    if (sbq.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
